// File: rtl/mult_div_unit_if.sv
// Handshake and result bus between the EX stage and the HI/LO multiply/divide unit.
interface mult_div_unit_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        wr_hi;
    logic        wr_lo;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, op_a, op_b, flush, wr_hi, wr_lo, wr_data,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, op_a, op_b, flush, wr_hi, wr_lo, wr_data,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative 32-cycle MIPS-style multiply/divide unit owning the HI/LO registers.
// Operates on magnitudes and fixes the signs of the results on the final iteration.
module mult_div_unit (
    input  logic             clk,
    input  logic             rst_n,
    mult_div_unit_if.slave   bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [4:0]  r_cnt;
    logic        r_is_div;
    logic        r_neg_q;
    logic        r_neg_r;
    logic [31:0] r_opd;
    logic [63:0] r_work;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_done;

    logic        w_signed;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic        w_launch;
    logic        w_last;
    logic [32:0] w_sum;
    logic [32:0] w_rem_sh;
    logic [32:0] w_trial;
    logic [63:0] w_work_next;
    logic [63:0] w_prod_fix;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;

    assign w_signed = ~bus.op[0];
    assign w_mag_a  = (w_signed && bus.op_a[31]) ? (~bus.op_a + 32'd1) : bus.op_a;
    assign w_mag_b  = (w_signed && bus.op_b[31]) ? (~bus.op_b + 32'd1) : bus.op_b;
    assign w_launch = (r_state == IDLE) && bus.start && !bus.flush;
    assign w_last   = (r_state == RUN) && (r_cnt == 5'd31) && !bus.flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (w_launch) w_state_next = RUN;
            RUN:  if (bus.flush || (r_cnt == 5'd31)) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // r_work holds {partial product, multiplier} or {partial remainder, dividend/quotient}.
    always_comb begin
        w_sum    = {1'b0, r_work[63:32]} + (r_work[0] ? {1'b0, r_opd} : 33'd0);
        w_rem_sh = {r_work[63:32], r_work[31]};
        w_trial  = w_rem_sh - {1'b0, r_opd};
        if (r_is_div) begin
            w_work_next = w_trial[32] ? {w_rem_sh[31:0], r_work[30:0], 1'b0}
                                      : {w_trial[31:0], r_work[30:0], 1'b1};
        end else begin
            w_work_next = {w_sum, r_work[31:1]};
        end
        w_prod_fix = r_neg_q ? (~w_work_next + 64'd1) : w_work_next;
        w_quo_fix  = r_neg_q ? (~w_work_next[31:0] + 32'd1) : w_work_next[31:0];
        w_rem_fix  = r_neg_r ? (~w_work_next[63:32] + 32'd1) : w_work_next[63:32];
    end

    // Divide by zero keeps the quotient unnegated so it stays all ones; remainder follows A.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= 5'd0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_opd    <= 32'd0;
            r_work   <= 64'd0;
        end else if (w_launch) begin
            r_cnt    <= 5'd0;
            r_is_div <= bus.op[1];
            r_neg_q  <= w_signed && (bus.op_a[31] ^ bus.op_b[31]) && (bus.op_b != 32'd0);
            r_neg_r  <= w_signed && bus.op_a[31];
            r_opd    <= bus.op[1] ? w_mag_b : w_mag_a;
            r_work   <= {32'd0, bus.op[1] ? w_mag_a : w_mag_b};
        end else if (r_state == RUN) begin
            r_cnt    <= r_cnt + 5'd1;
            r_work   <= w_work_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi   <= 32'd0;
            r_lo   <= 32'd0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_last) begin
                if (r_is_div) begin
                    r_hi <= w_rem_fix;
                    r_lo <= w_quo_fix;
                end else begin
                    r_hi <= w_prod_fix[63:32];
                    r_lo <= w_prod_fix[31:0];
                end
            end else if (r_state == IDLE) begin
                if (bus.wr_hi) r_hi <= bus.wr_data;
                if (bus.wr_lo) r_lo <= bus.wr_data;
            end
        end
    end

    assign bus.busy = (r_state == RUN);
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed plus random checks of mult_div_unit against an arithmetic reference model.
module tb_mult_div_unit;
    logic clk;
    logic rst_n;
    int   vectors = 0;
    int   errors  = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mult_div_unit_if bus();

    mult_div_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l);
        longint sp;
        logic [63:0] up;
        int sa, sb;
        sa = a;
        sb = b;
        h = 32'd0;
        l = 32'd0;
        case (op)
            2'b00: begin
                sp = longint'(sa) * longint'(sb);
                {h, l} = sp;
            end
            2'b01: begin
                up = {32'd0, a} * {32'd0, b};
                {h, l} = up;
            end
            2'b10: begin
                if (b == 32'd0) begin
                    l = 32'hFFFFFFFF; h = a;
                end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                    l = 32'h80000000; h = 32'd0;
                end else begin
                    l = sa / sb; h = sa % sb;
                end
            end
            default: begin
                if (b == 32'd0) begin
                    l = 32'hFFFFFFFF; h = a;
                end else begin
                    l = a / b; h = a % b;
                end
            end
        endcase
    endfunction

    // Called at a negedge; applies start for one edge and returns at the negedge after E0.
    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.op_a  = a;
        bus.op_b  = b;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic finish(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int skip);
        logic [31:0] eh, el;
        int n;
        model(op, a, b, eh, el);
        n = skip;
        while (bus.busy === 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'd32);
        chk({tag, "_done"}, 64'(bus.done), 64'd1);
        chk({tag, "_hi"}, 64'(bus.hi), 64'(eh));
        chk({tag, "_lo"}, 64'(bus.lo), 64'(el));
        $display("%s op=%0d a=%h b=%h -> hi=%h lo=%h", tag, op, a, b, bus.hi, bus.lo);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
        m_hi = eh;
        m_lo = el;
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        launch(op, a, b);
        finish(tag, op, a, b, 0);
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0: v = 32'd0;
            1: v = 32'h80000000;
            2: v = 32'hFFFFFFFF;
            3: v = $urandom_range(0, 20);
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.op      = 2'b00;
        bus.op_a    = 32'd0;
        bus.op_b    = 32'd0;
        bus.flush   = 1'b0;
        bus.wr_hi   = 1'b0;
        bus.wr_lo   = 1'b0;
        bus.wr_data = 32'd0;
        #1;
        chk("reset_hi", 64'(bus.hi), 64'd0);
        chk("reset_lo", 64'(bus.lo), 64'd0);
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_done", 64'(bus.done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_op("mult_neg2x7", 2'b00, 32'hFFFFFFFE, 32'd7);
        run_op("div_m7_2", 2'b10, 32'hFFFFFFF9, 32'd2);
        run_op("divu_by0", 2'b11, 32'd100, 32'd0);
        run_op("div_min_m1", 2'b10, 32'h80000000, 32'hFFFFFFFF);
        run_op("div_neg_by0", 2'b10, 32'hFFFFFF00, 32'd0);

        for (int i = 0; i < 24; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = pick();
            rb  = pick();
            run_op($sformatf("rand%0d", i), rop, ra, rb);
        end

        // Second start during RUN must be ignored.
        launch(2'b01, 32'd3, 32'd5);
        bus.start = 1'b1; bus.op = 2'b10; bus.op_a = 32'd100; bus.op_b = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        finish("start_in_run", 2'b01, 32'd3, 32'd5, 5);

        // Flush mid-run: busy drops, no done, HI/LO untouched.
        launch(2'b11, 32'd9, 32'd2);
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush_busy", 64'(bus.busy), 64'd0);
        chk("flush_done", 64'(bus.done), 64'd0);
        chk("flush_hi", 64'(bus.hi), 64'(m_hi));
        chk("flush_lo", 64'(bus.lo), 64'(m_lo));
        $display("flush_mid hi=%h lo=%h", bus.hi, bus.lo);
        @(negedge clk);
        chk("flush_done_after", 64'(bus.done), 64'd0);

        // Flush exactly at the final edge wins over the HI/LO update.
        launch(2'b00, 32'd1234, 32'd5678);
        repeat (31) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flushE32_busy", 64'(bus.busy), 64'd0);
        chk("flushE32_done", 64'(bus.done), 64'd0);
        chk("flushE32_hi", 64'(bus.hi), 64'(m_hi));
        chk("flushE32_lo", 64'(bus.lo), 64'(m_lo));
        $display("flush_e32 hi=%h lo=%h", bus.hi, bus.lo);

        // Flush in IDLE suppresses start.
        bus.flush = 1'b1; bus.start = 1'b1; bus.op = 2'b01;
        @(negedge clk);
        bus.flush = 1'b0; bus.start = 1'b0;
        chk("flush_idle_busy", 64'(bus.busy), 64'd0);
        $display("flush_idle busy=%b", bus.busy);

        // MTHI / MTLO in IDLE.
        bus.wr_hi = 1'b1; bus.wr_data = 32'h1234;
        @(negedge clk);
        bus.wr_hi = 1'b0;
        m_hi = 32'h1234;
        chk("mthi_hi", 64'(bus.hi), 64'(m_hi));
        chk("mthi_lo", 64'(bus.lo), 64'(m_lo));
        bus.wr_hi = 1'b1; bus.wr_lo = 1'b1; bus.wr_data = 32'h5555AAAA;
        @(negedge clk);
        bus.wr_hi = 1'b0; bus.wr_lo = 1'b0;
        m_hi = 32'h5555AAAA; m_lo = 32'h5555AAAA;
        chk("mthilo_hi", 64'(bus.hi), 64'(m_hi));
        chk("mthilo_lo", 64'(bus.lo), 64'(m_lo));
        $display("mthi/mtlo hi=%h lo=%h", bus.hi, bus.lo);

        // MTHI during RUN is ignored; completion overwrites.
        launch(2'b00, 32'hFFFFFF85, 32'd300);
        bus.wr_hi = 1'b1; bus.wr_data = 32'hDEAD;
        @(negedge clk);
        bus.wr_hi = 1'b0;
        chk("mthi_run_hi", 64'(bus.hi), 64'(m_hi));
        finish("mthi_run", 2'b00, 32'hFFFFFF85, 32'd300, 1);

        // Start with simultaneous writes: writes land, then the result overwrites.
        bus.wr_hi = 1'b1; bus.wr_lo = 1'b1; bus.wr_data = 32'h7777;
        launch(2'b11, 32'd1000, 32'd7);
        bus.wr_hi = 1'b0; bus.wr_lo = 1'b0;
        chk("start_wr_hi", 64'(bus.hi), 64'h7777);
        chk("start_wr_lo", 64'(bus.lo), 64'h7777);
        chk("start_wr_busy", 64'(bus.busy), 64'd1);
        finish("start_wr", 2'b11, 32'd1000, 32'd7, 0);

        // Asynchronous reset mid-MULT.
        launch(2'b00, 32'hFFFFFFF0, 32'd77);
        repeat (14) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_hi", 64'(bus.hi), 64'd0);
        chk("areset_lo", 64'(bus.lo), 64'd0);
        chk("areset_busy", 64'(bus.busy), 64'd0);
        chk("areset_done", 64'(bus.done), 64'd0);
        $display("async_reset hi=%h lo=%h busy=%b", bus.hi, bus.lo, bus.busy);
        @(negedge clk);
        rst_n = 1'b1;
        m_hi = 32'd0; m_lo = 32'd0;
        run_op("after_reset", 2'b00, 32'hFFFFFFF0, 32'd77);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have no parameters; all widths are fixed at 32 bits.
REQ-002 clk  in  1  single clock; all state updates occur on the rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 start  in  1  launch the operation selected by op with operands op_a/op_b.
REQ-005 op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 op_a  in  32  operand A (rs), taken from the EX forwarding mux output.
REQ-007 op_b  in  32  operand B (rt), taken from the EX forwarding mux output.
REQ-008 flush  in  1  abort the in-flight operation (pipeline flush).
REQ-009 wr_hi  in  1  MTHI strobe.
REQ-010 wr_lo  in  1  MTLO strobe.
REQ-011 wr_data  in  32  MTHI/MTLO data.
REQ-012 busy  out  1  operation in flight; the hazard unit stalls MFHI/MFLO/mult/div on it.
REQ-013 done  out  1  one-cycle pulse when HI/LO are updated by a completed operation.
REQ-014 hi  out  32  HI register.
REQ-015 lo  out  32  LO register.

Function
REQ-016 SHALL implement a two-state FSM, IDLE and RUN, with a 5-bit iteration counter.
REQ-017 In IDLE, start=1 at edge E0 SHALL latch op, |A|/|B| magnitudes (signed ops) or raw values (unsigned ops) and the result signs, clear the counter and enter RUN.
REQ-018 RUN SHALL perform one iteration per edge for 32 edges (E1..E32): shift-add for multiply, restoring shift-subtract for divide.
REQ-019 At E32 SHALL load hi/lo, pulse done for the following cycle, and return to IDLE.
REQ-020 busy SHALL be 1 exactly while the state is RUN (cycles after E0 through E32), and combinationally 0 in IDLE.
REQ-021 Multiply SHALL produce {hi,lo} = the 64-bit product: two's-complement for MULT, unsigned for MULTU.
REQ-022 Divide SHALL produce lo = quotient and hi = remainder.
REQ-023 For DIV, the quotient sign SHALL be sign(A) XOR sign(B), the remainder sign SHALL be sign(A), and the quotient SHALL truncate toward zero.
REQ-024 DIV 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0x00000000.
REQ-025 Divide by zero (DIV or DIVU) SHALL give lo=0xFFFFFFFF, hi=op_a, taking the full 32-cycle latency.
REQ-026 start while in RUN SHALL be ignored; no queuing.
REQ-027 flush=1 in RUN SHALL return the FSM to IDLE on the next edge, leave hi/lo unchanged and assert no done.
REQ-028 flush=1 in IDLE SHALL suppress a simultaneous start.
REQ-029 flush at E32 SHALL take priority, so no hi/lo update occurs.
REQ-030 wr_hi / wr_lo in IDLE SHALL write wr_data to hi / lo on that edge.
REQ-031 wr_hi / wr_lo in RUN SHALL be ignored.
REQ-032 wr_hi and wr_lo together SHALL write both registers.
REQ-033 start together with wr_hi/wr_lo in IDLE SHALL perform the write and launch the operation; the completion later overwrites both registers.
REQ-034 done SHALL never be high for two consecutive cycles.

Reset
REQ-035 rst_n=0 SHALL immediately force state=IDLE, counter=0, hi=0, lo=0, busy=0, done=0, independent of clk.
REQ-036 Reset asserted mid-operation SHALL discard the operation; after release the unit SHALL accept start on the first edge.

Verification
REQ-037 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> busy 32 cycles, then done pulse and hi=0xFFFFFFFE, lo=0x00000001.
REQ-038 MULT 0xFFFFFFFE (-2) x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFF2; then DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-039 DIVU 100 / 0 -> lo=0xFFFFFFFF, hi=100; DIV 0x80000000 / -1 -> lo=0x80000000, hi=0.
REQ-040 Start DIVU 9/2, pulse flush at cycle 10 -> busy drops the next cycle, no done, hi/lo keep prior values; a second start in RUN is ignored.
REQ-041 wr_hi=1 with wr_data=0x1234 in IDLE -> hi=0x1234; the same strobe during RUN -> hi unchanged until completion.
REQ-042 Drop rst_n asynchronously at cycle 15 of a MULT -> hi=lo=0, busy=0 immediately; a new start after release completes correctly.
